// File: rtl/sample_tx_fifo.sv
// Stereo sample FIFO between the FIR stage and the codec write port.
// Holds output until THRESH pairs are buffered, then streams while the codec is ready.
module sample_tx_fifo #(
    parameter int W      = 16,
    parameter int DEPTH  = 8,
    parameter int THRESH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [W-1:0]  in_left,
    input  logic [W-1:0]  in_right,
    input  logic          in_valid,
    input  logic          write_ready,
    output logic          write,
    output logic [23:0]   writedata_left,
    output logic [23:0]   writedata_right,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic          underrun,
    input  logic          clr_flags
);

    // state | meaning
    // FILL  | priming: collecting pairs, codec output held off
    // RUN   | streaming: pop one pair per codec-ready cycle
    typedef enum logic {FILL, RUN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            overflow_q, overflow_d;
    logic            underrun_q, underrun_d;
    logic [2*W-1:0]  mem_q [DEPTH];

    logic            push;
    logic            pop;
    logic            drop;
    logic            starve;
    logic [W-1:0]    head_left;
    logic [W-1:0]    head_right;
    logic [23:0]     head_left24;
    logic [23:0]     head_right24;

    assign head_left  = mem_q[rd_ptr_q][2*W-1:W];
    assign head_right = mem_q[rd_ptr_q][W-1:0];

    // Left-justify into the 24-bit codec word; wider samples keep their MSBs.
    generate
        if (W >= 24) begin : g_trunc
            assign head_left24  = head_left[W-1 -: 24];
            assign head_right24 = head_right[W-1 -: 24];
        end else begin : g_pad
            assign head_left24  = {head_left,  {(24-W){1'b0}}};
            assign head_right24 = {head_right, {(24-W){1'b0}}};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        pop        = (state_q == RUN) && write_ready && (level_q != '0);
        starve     = (state_q == RUN) && write_ready && (level_q == '0);
        push       = in_valid && ((level_q < LW'(DEPTH)) || pop);
        drop       = in_valid && !push;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        overflow_d = drop   ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);
        underrun_d = starve ? 1'b1 : (clr_flags ? 1'b0 : underrun_q);

        case (state_q)
            FILL: if (level_d >= LW'(THRESH)) state_d = RUN;
            RUN:  if (starve)                 state_d = FILL;
            default:                          state_d = FILL;
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge ck) begin
        if (push) mem_q[wr_ptr_q] <= {in_left, in_right};
    end

    assign write           = pop;
    assign writedata_left  = pop ? head_left24  : 24'd0;
    assign writedata_right = pop ? head_right24 : 24'd0;
    assign level           = level_q;
    assign overflow        = overflow_q;
    assign underrun        = underrun_q;

endmodule

// File: tb/tb_sample_tx_fifo.sv
// Bench for sample_tx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a random soak.
module tb_sample_tx_fifo;

    localparam int W = 16;
    localparam int DEPTH = 8;
    localparam int THRESH = 4;

    logic        ck;
    logic        rst;
    logic [15:0] in_left;
    logic [15:0] in_right;
    logic        in_valid;
    logic        write_ready;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;
    logic [3:0]  level;
    logic        overflow;
    logic        underrun;
    logic        clr_flags;

    int n_pass = 0;
    int n_total = 0;

    sample_tx_fifo #(.W(W), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .ck              (ck),
        .rst             (rst),
        .in_left         (in_left),
        .in_right        (in_right),
        .in_valid        (in_valid),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .level           (level),
        .overflow        (overflow),
        .underrun        (underrun),
        .clr_flags       (clr_flags)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [23:0] to24(input logic [15:0] d);
        return {d, 8'h00};
    endfunction

    // Reference model: a plain queue of pairs, a primed/running bit and two flags.
    logic [15:0] ql[$];
    logic [15:0] qr[$];
    bit m_run, m_ovf, m_und;

    always @(negedge ck or negedge rst) begin
        int  sz;
        bit  e_pop, e_push, e_starve;
        if (!rst) begin
            ql.delete();
            qr.delete();
            m_run = 0;
            m_ovf = 0;
            m_und = 0;
            if (!ck) begin
                chk("rst_write", write, 0);
                chk("rst_wdl", writedata_left, 0);
                chk("rst_wdr", writedata_right, 0);
                chk("rst_level", level, 0);
                chk("rst_flags", {overflow, underrun}, 0);
            end
        end else if (!ck) begin
            sz = ql.size();
            e_pop    = m_run && write_ready && (sz > 0);
            e_starve = m_run && write_ready && (sz == 0);
            e_push   = in_valid && ((sz < DEPTH) || e_pop);
            chk("write", write, e_pop);
            chk("wdl", writedata_left,  e_pop ? to24(ql[0]) : 24'd0);
            chk("wdr", writedata_right, e_pop ? to24(qr[0]) : 24'd0);
            chk("level", level, sz);
            chk("level_bound", level <= DEPTH, 1);
            chk("overflow", overflow, m_ovf);
            chk("underrun", underrun, m_und);
            // advance the model to the state after the coming rising edge
            if (e_pop) begin
                void'(ql.pop_front());
                void'(qr.pop_front());
            end
            if (e_push) begin
                ql.push_back(in_left);
                qr.push_back(in_right);
            end
            if (in_valid && !e_push) m_ovf = 1;
            else if (clr_flags)      m_ovf = 0;
            if (e_starve)            m_und = 1;
            else if (clr_flags)      m_und = 0;
            if (!m_run) begin
                if (ql.size() >= THRESH) m_run = 1;
            end else if (e_starve) begin
                m_run = 0;
            end
        end
    end

    task automatic set_in(input logic iv, input logic [15:0] l, input logic [15:0] r,
                          input logic wr, input logic clr);
        in_valid    = iv;
        in_left     = l;
        in_right    = r;
        write_ready = wr;
        clr_flags   = clr;
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic cyc(input logic iv, input logic [15:0] l, input logic [15:0] r,
                       input logic wr, input logic clr);
        set_in(iv, l, r, wr, clr);
        tick();
    endtask

    initial begin
        int pct;
        rst = 1'b0;
        set_in(0, 16'h0, 16'h0, 1, 0);
        repeat (3) tick();
        chk("lit_rst_level", level, 0);
        rst = 1'b1;

        // prime: output held until four pairs are stored
        cyc(1, 16'h1111, 16'h2222, 1, 0);
        chk("lit_first_push_level", level, 1);
        cyc(1, 16'h3333, 16'h4444, 1, 0);
        cyc(1, 16'h5555, 16'h6666, 1, 0);
        set_in(1, 16'h7777, 16'h8888, 1, 0);
        #1;
        chk("lit_prime_hold", write, 0);
        tick();
        set_in(0, 16'h0, 16'h0, 1, 0);
        #1;
        chk("lit_prime_write", write, 1);
        chk("lit_prime_wdl", writedata_left, 24'h111100);
        chk("lit_prime_wdr", writedata_right, 24'h222200);
        chk("lit_prime_level", level, 4);
        repeat (4) tick();
        chk("lit_drained", level, 0);
        set_in(0, 16'h0, 16'h0, 1, 0);
        #1;
        chk("lit_empty_nowrite", write, 0);
        tick();
        chk("lit_underrun_set", underrun, 1);

        // refill after underrun, then clear the flag
        for (int i = 0; i < 3; i++) cyc(1, 16'hA000 + 16'(i), 16'hB000 + 16'(i), 1, 0);
        chk("lit_refill_hold", write, 0);
        cyc(1, 16'hA003, 16'hB003, 1, 0);
        cyc(0, 16'h0, 16'h0, 0, 1);
        chk("lit_underrun_clr", underrun, 0);
        chk("lit_refill_level", level, 4);
        repeat (4) cyc(0, 16'h0, 16'h0, 1, 0);
        cyc(0, 16'h0, 16'h0, 0, 0);

        // overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) cyc(1, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 0, 0);
        chk("lit_ovf_level", level, 8);
        chk("lit_ovf_flag", overflow, 1);
        cyc(0, 16'h0, 16'h0, 0, 1);
        chk("lit_ovf_clr", overflow, 0);

        // full with simultaneous push and pop
        set_in(1, 16'hAAAA, 16'hBBBB, 1, 0);
        #1;
        chk("lit_full_wdl", writedata_left, 24'h010000);
        chk("lit_full_wdr", writedata_right, 24'h020000);
        tick();
        chk("lit_full_level", level, 8);
        chk("lit_full_noovf", overflow, 0);
        repeat (8) cyc(0, 16'h0, 16'h0, 1, 0);
        chk("lit_full_drained", level, 0);
        cyc(0, 16'h0, 16'h0, 1, 0);
        chk("lit_underrun2", underrun, 1);

        // reset mid-stream with five pairs stored
        for (int i = 0; i < 5; i++) cyc(1, 16'hD000 + 16'(i), 16'hE000 + 16'(i), 0, 0);
        chk("lit_pre_rst_level", level, 5);
        set_in(0, 16'h0, 16'h0, 1, 0);
        #1;
        chk("lit_pre_rst_write", write, 1);
        rst = 1'b0;
        #1;
        chk("lit_async_level", level, 0);
        chk("lit_async_write", write, 0);
        chk("lit_async_wd", {writedata_left, writedata_right}, 0);
        chk("lit_async_flags", {overflow, underrun}, 0);
        #1;
        rst = 1'b1;
        repeat (3) cyc(0, 16'h0, 16'h0, 1, 0);
        chk("lit_no_stale", write, 0);

        // random soak with varying codec readiness
        for (int blk = 0; blk < 10; blk++) begin
            pct = (blk % 5) * 25;
            for (int c = 0; c < 1000; c++) begin
                cyc(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 99) < pct), 1'($urandom_range(0, 31) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sample_tx_fifo.md
SAMPLE_TX_FIFO -- requirements
Module: sample_tx_fifo

Interface
REQ-001 The block SHALL have the following parameters:
- W, default 16: filter sample width.
- DEPTH, default 8: FIFO entries; power of 2, 4..64.
- THRESH, default 4: prime level; 1 <= THRESH <= DEPTH.

REQ-002 The block SHALL have one clock and an asynchronous active-low reset. Ports, in order:
- ck  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_left  in  W  left sample from the FIR stage.
- in_right  in  W  right sample from the FIR stage.
- in_valid  in  1  one-cycle strobe; in_left/in_right valid this cycle.
- write_ready  in  1  codec can accept a stereo pair this cycle.
- write  out  1  codec write strobe.
- writedata_left  out  24  to codec.
- writedata_right  out  24  to codec.
- level  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: an input pair was dropped.
- underrun  out  1  sticky: codec was starved while running.
- clr_flags  in  1  synchronous clear of overflow and underrun.

Function
REQ-003 Storage SHALL be a circular buffer of DEPTH stereo entries, each 2*W bits, with read and write pointers that wrap from DEPTH-1 to 0.
REQ-004 A push SHALL occur on the edge where in_valid=1 and (level<DEPTH or a pop occurs in the same cycle).
REQ-005 If in_valid=1, level==DEPTH and no pop occurs, the pair SHALL be discarded, level SHALL stay unchanged, and overflow SHALL be set.
REQ-006 The controller SHALL be an FSM with two states, FILL and RUN. Reset state is FILL.
REQ-007 FILL->RUN SHALL happen on the edge where level after update is >= THRESH. No pop SHALL occur in FILL.
REQ-008 In RUN, write SHALL be write_ready AND (level>0), combinationally. A pop (read pointer +1) SHALL occur on each edge where write=1.
REQ-009 In RUN, write_ready=1 with level==0 SHALL set underrun and move the FSM to FILL on that edge.
REQ-010 On a simultaneous push and pop, level SHALL be unchanged and both pointers SHALL advance.
REQ-011 When write=1, writedata_left SHALL be {head_left, (24-W) zero bits}; writedata_right likewise. When write=0, both SHALL be 0.
REQ-012 For W>24, the upper 24 bits SHALL be used and the low bits dropped.
REQ-013 Latency: a pair pushed on edge N SHALL be at the head in cycle N+1. In RUN with write_ready=1 it SHALL appear on writedata in cycle N+1.
REQ-014 clr_flags=1 SHALL clear both flags on the next edge. If a set condition occurs in the same cycle, set SHALL win.
REQ-015 Data SHALL leave in arrival order with no duplication. Nothing dropped except under REQ-005.
REQ-016 level SHALL always equal (pushes - pops) and stay within 0..DEPTH.

Reset
REQ-017 rst=0 SHALL asynchronously force the following, regardless of ck:
- pointers = 0, level = 0, state = FILL;
- overflow = underrun = 0;
- write = 0, writedata_* = 0.
REQ-018 Reset asserted mid-stream SHALL discard all stored pairs.
REQ-019 After rst rises, the first accepted push SHALL be the first edge with in_valid=1.

Verification
REQ-020 Prime: with write_ready=1, push 0x1111/0x2222, then 0x3333/0x4444, 0x5555/0x6666, 0x7777/0x8888.
-> write stays 0 until level reaches 4.
-> Next cycle: write=1, writedata_left=0x111100, writedata_right=0x222200.
REQ-021 Overflow: write_ready=0, 9 pushes with DEPTH=8.
-> level=8, overflow=1.
-> The 9th pair is never output; the 8 stored pairs drain in order.
REQ-022 Full plus simultaneous push/pop: RUN, level=8, in_valid=1 and write_ready=1 in the same cycle.
-> level stays 8, overflow stays 0, pointers wrap correctly.
REQ-023 Underrun: RUN, drain to level 0 while write_ready stays 1.
-> underrun=1 next edge, state=FILL.
-> write=0 until 4 new pushes; clr_flags then clears underrun.
REQ-024 Reset mid-stream: level=5, assert rst=0 between clock edges.
-> level=0, write=0, outputs 0 immediately, before the next edge.
-> After release, no stale data is ever output.
REQ-025 Random soak: random in_valid and write_ready for 10k cycles, compared against a reference queue.
-> Output sequence matches exactly; level never exceeds DEPTH; flags are consistent with the queue model.
